// File: rtl/bus_timer_responder.sv
// bus_timer_responder: memory-mapped machine timer on the core data bus.
// Registers (word offset = bus_address[4:2]):
//   0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI,
//   4 CTRL (bit0 enable, bits[8+PRESCALE_WIDTH-1:8] divider D), 5 STATUS (bit0 irq),
//   6-7 unmapped (read 0, writes ignored).
// Bus handshake: a read is requested when bus_read_enable is high and returns
// data combinationally in the same cycle; a write is requested when
// bus_write_enable is high and commits at the next rising clock edge. Both are
// only honoured while selected is high; there is no wait state and no back-pressure.
// Optional macro TIMER_READ_LATCH_EN: a read of MTIME_LO latches mtime[63:32]
// into a shadow register that MTIME_HI then returns, for coherent 64-bit reads.
module bus_timer_responder #(
    parameter logic [31:0] BASE_ADDRESS   = 32'h8000_1000,
    parameter int          PRESCALE_WIDTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic [3:0]  bus_byte_enable,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    output logic [31:0] bus_read_data,
    output logic        selected,
    output logic        timer_interrupt
);

    localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
    localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] OFF_CTRL        = 3'd4;
    localparam logic [2:0] OFF_STATUS      = 3'd5;

    logic [63:0]               r_mtime;
    logic [63:0]               r_mtimecmp;
    logic                      r_enable;
    logic [PRESCALE_WIDTH-1:0] r_divider;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic                      r_irq;
`ifdef TIMER_READ_LATCH_EN
    logic [31:0]               r_shadow;
`endif

    logic [2:0]  w_offset;
    logic        w_read;
    logic        w_write;
    logic        w_tick;
    logic [31:0] w_ctrl_word;
    logic [31:0] w_ctrl_merged;
    logic [31:0] w_read_data;
    logic        w_unused;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    assign selected    = (bus_address[31:5] == BASE_ADDRESS[31:5]);
    assign w_offset    = bus_address[4:2];
    assign w_read      = selected && bus_read_enable;
    // A write with no byte strobes is treated as no access at all.
    assign w_write     = selected && bus_write_enable && (bus_byte_enable != 4'b0000);
    // Wrap whenever the count has reached or overshot D (D may shrink under it).
    assign w_tick      = r_enable && (r_prescale >= r_divider);
    assign w_ctrl_word = {{(24 - PRESCALE_WIDTH){1'b0}}, r_divider, 7'b0, r_enable};
    assign w_ctrl_merged = merge_bytes(w_ctrl_word, bus_write_data, bus_byte_enable);
    assign w_unused    = ^{bus_address[1:0], w_ctrl_merged};

    // Combinational read mux of current flop state (pre-write on collision).
    always_comb begin
        w_read_data = 32'h0;
        if (w_read) begin
            case (w_offset)
                OFF_MTIME_LO:    w_read_data = r_mtime[31:0];
`ifdef TIMER_READ_LATCH_EN
                OFF_MTIME_HI:    w_read_data = r_shadow;
`else
                OFF_MTIME_HI:    w_read_data = r_mtime[63:32];
`endif
                OFF_MTIMECMP_LO: w_read_data = r_mtimecmp[31:0];
                OFF_MTIMECMP_HI: w_read_data = r_mtimecmp[63:32];
                OFF_CTRL:        w_read_data = w_ctrl_word;
                OFF_STATUS:      w_read_data = {31'b0, r_irq};
                default:         w_read_data = 32'h0;
            endcase
        end
    end

    assign bus_read_data   = w_read_data;
    assign timer_interrupt = r_irq;

    // mtime and prescaler: a bus write to mtime beats the increment and restarts the prescaler.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mtime    <= 64'h0;
            r_prescale <= '0;
        end else if (w_write && (w_offset == OFF_MTIME_LO)) begin
            r_mtime[31:0] <= merge_bytes(r_mtime[31:0], bus_write_data, bus_byte_enable);
            r_prescale    <= '0;
        end else if (w_write && (w_offset == OFF_MTIME_HI)) begin
            r_mtime[63:32] <= merge_bytes(r_mtime[63:32], bus_write_data, bus_byte_enable);
            r_prescale     <= '0;
        end else if (w_tick) begin
            r_mtime    <= r_mtime + 64'd1;
            r_prescale <= '0;
        end else if (r_enable) begin
            r_prescale <= r_prescale + PRESCALE_WIDTH'(1);
        end
    end

    // Compare register and control word, byte-lane writable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_enable   <= 1'b0;
            r_divider  <= '0;
        end else if (w_write) begin
            if (w_offset == OFF_MTIMECMP_LO) begin
                r_mtimecmp[31:0] <= merge_bytes(r_mtimecmp[31:0], bus_write_data, bus_byte_enable);
            end
            if (w_offset == OFF_MTIMECMP_HI) begin
                r_mtimecmp[63:32] <= merge_bytes(r_mtimecmp[63:32], bus_write_data, bus_byte_enable);
            end
            if (w_offset == OFF_CTRL) begin
                r_enable  <= w_ctrl_merged[0];
                r_divider <= w_ctrl_merged[8 +: PRESCALE_WIDTH];
            end
        end
    end

    // Registered level interrupt from the current-cycle unsigned compare.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_mtime >= r_mtimecmp);
        end
    end

`ifdef TIMER_READ_LATCH_EN
    // Latch the high word whenever software reads the low word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shadow <= 32'h0;
        end else if (w_read && (w_offset == OFF_MTIME_LO)) begin
            r_shadow <= r_mtime[63:32];
        end
    end
`endif

endmodule

// File: tb/tb_bus_timer_responder.sv
// Bench for bus_timer_responder: directed scenarios with literal expectations,
// then randomized bus traffic compared every cycle against a behavioural model.
module tb_bus_timer_responder;

    localparam logic [31:0] BASE = 32'h8000_1000;
    localparam int          PW   = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] bus_address = BASE;
    logic [31:0] bus_write_data = 32'h0;
    logic [3:0]  bus_byte_enable = 4'h0;
    logic        bus_read_enable = 1'b0;
    logic        bus_write_enable = 1'b0;
    logic [31:0] bus_read_data;
    logic        selected;
    logic        timer_interrupt;

    int n_cmp = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [63:0] m_mtime  = 64'h0;
    logic [63:0] m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
    logic        m_en     = 1'b0;
    int unsigned m_d      = 0;
    int unsigned m_pc     = 0;
    logic        m_irq    = 1'b0;
    logic [31:0] m_shadow = 32'h0;

    bus_timer_responder #(
        .BASE_ADDRESS   (BASE),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_byte_enable  (bus_byte_enable),
        .bus_read_enable  (bus_read_enable),
        .bus_write_enable (bus_write_enable),
        .bus_read_data    (bus_read_data),
        .selected         (selected),
        .timer_interrupt  (timer_interrupt)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] ctrl_value();
        return (32'(m_d) << 8) | {31'b0, m_en};
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] off);
        case (off)
            3'd0: return m_mtime[31:0];
`ifdef TIMER_READ_LATCH_EN
            3'd1: return m_shadow;
`else
            3'd1: return m_mtime[63:32];
`endif
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return ctrl_value();
            3'd5: return {31'b0, m_irq};
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge of the timer as the register map describes it.
    task automatic model_step();
        logic        sel;
        logic        wr;
        logic        rd;
        logic [2:0]  off;
        logic [63:0] nt;
        int unsigned npc;
        logic [31:0] cw;
        sel = (bus_address[31:5] == BASE[31:5]);
        off = bus_address[4:2];
        wr  = sel && bus_write_enable && (bus_byte_enable != 4'h0);
        rd  = sel && bus_read_enable;
        nt  = m_mtime;
        npc = m_pc;
        if (wr && (off == 3'd0 || off == 3'd1)) begin
            if (off == 3'd0) nt[31:0]  = merge(m_mtime[31:0], bus_write_data, bus_byte_enable);
            else             nt[63:32] = merge(m_mtime[63:32], bus_write_data, bus_byte_enable);
            npc = 0;
        end else if (m_en) begin
            if (m_pc >= m_d) begin
                nt  = m_mtime + 64'd1;
                npc = 0;
            end else begin
                npc = m_pc + 1;
            end
        end
        m_irq   <= (m_mtime >= m_cmp);
        m_mtime <= nt;
        m_pc    <= npc;
        if (rd && off == 3'd0) m_shadow <= m_mtime[63:32];
        if (wr && off == 3'd2) m_cmp[31:0]  <= merge(m_cmp[31:0], bus_write_data, bus_byte_enable);
        if (wr && off == 3'd3) m_cmp[63:32] <= merge(m_cmp[63:32], bus_write_data, bus_byte_enable);
        if (wr && off == 3'd4) begin
            cw = merge(ctrl_value(), bus_write_data, bus_byte_enable);
            m_en <= cw[0];
            m_d  <= (cw >> 8) & ((32'd1 << PW) - 32'd1);
        end
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_mtime  <= 64'h0;
            m_cmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
            m_en     <= 1'b0;
            m_d      <= 0;
            m_pc     <= 0;
            m_irq    <= 1'b0;
            m_shadow <= 32'h0;
        end else begin
            model_step();
        end
    end

    // ---------------- scoreboard: compare every cycle ----------------
    always @(negedge clock) begin
        logic        exp_sel;
        logic [31:0] exp_rd;
        exp_sel = (bus_address[31:5] == BASE[31:5]);
        exp_rd  = (exp_sel && bus_read_enable) ? model_read(bus_address[4:2]) : 32'h0;
        check("selected", {63'b0, selected}, {63'b0, exp_sel});
        check("read_data", {32'b0, bus_read_data}, {32'b0, exp_rd});
        check("timer_interrupt", {63'b0, timer_interrupt}, {63'b0, m_irq});
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        bus_read_enable  = 1'b0;
        bus_write_enable = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wr_addr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        bus_address      = a;
        bus_write_data   = d;
        bus_byte_enable  = b;
        bus_write_enable = 1'b1;
        bus_read_enable  = 1'b0;
        @(posedge clock);
        #1;
        bus_write_enable = 1'b0;
        bus_byte_enable  = 4'h0;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] b);
        wr_addr(BASE | {27'b0, off, 2'b00}, d, b);
    endtask

    task automatic read_lit(input logic [2:0] off, input logic [31:0] exp, input string name);
        bus_address      = BASE | {27'b0, off, 2'b00};
        bus_read_enable  = 1'b1;
        bus_write_enable = 1'b0;
        #1;
        check(name, {32'b0, bus_read_data}, {32'b0, exp});
        @(posedge clock);
        #1;
        bus_read_enable = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rst_exp [8];
        logic [2:0]  off;
        logic [31:0] d;
        rst_exp = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};

        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        // Reset values
        check("rst_irq", {63'b0, timer_interrupt}, 64'h0);
        for (int i = 0; i < 8; i++) read_lit(3'(i), rst_exp[i], "rst_read");

        // Prescaler D=3: first increment after 4 cycles, 5 after 20, then freeze
        wr(3'd4, 32'h0000_0301, 4'hF);
        idle(4);
        read_lit(3'd0, 32'd1, "presc_first");
        idle(15);
        read_lit(3'd0, 32'd5, "presc_20");
        wr(3'd4, 32'h0, 4'hF);
        idle(10);
        read_lit(3'd0, 32'd5, "presc_frozen");

        // Carry from LO into HI
        wr(3'd0, 32'hFFFF_FFFE, 4'hF);
        wr(3'd1, 32'h0, 4'hF);
        wr(3'd4, 32'h1, 4'hF);
        idle(1);
        read_lit(3'd0, 32'hFFFF_FFFF, "carry_lo");
`ifdef TIMER_READ_LATCH_EN
        read_lit(3'd1, 32'h0, "carry_hi_shadow");
`else
        read_lit(3'd1, 32'h1, "carry_hi");
`endif
        read_lit(3'd0, 32'h1, "carry_lo_after");
        wr(3'd4, 32'h0, 4'hF);

        // Interrupt at mtime == mtimecmp == 10
        wr(3'd2, 32'd10, 4'hF);
        wr(3'd3, 32'h0, 4'hF);
        wr(3'd0, 32'h0, 4'hF);
        wr(3'd1, 32'h0, 4'hF);
        wr(3'd4, 32'h1, 4'hF);
        idle(10);
        check("irq_before", {63'b0, timer_interrupt}, 64'h0);
        idle(1);
        check("irq_rise", {63'b0, timer_interrupt}, 64'h1);
        read_lit(3'd5, 32'h1, "status");
        wr(3'd2, 32'd100, 4'hF);
        check("irq_hold", {63'b0, timer_interrupt}, 64'h1);
        idle(1);
        check("irq_drop", {63'b0, timer_interrupt}, 64'h0);
        wr(3'd4, 32'h0, 4'hF);

        // Byte strobes, unmapped and out-of-range writes
        wr(3'd2, 32'hFFFF_FFFF, 4'hF);
        wr(3'd2, 32'hAABB_CCDD, 4'b0101);
        read_lit(3'd2, 32'hFFBB_FFDD, "byte_en");
        wr(3'd6, 32'h1234_5678, 4'hF);
        wr_addr(BASE + 32'h28, 32'h1111_1111, 4'hF);
        wr_addr(BASE - 32'h18, 32'h2222_2222, 4'hF);
        wr(3'd2, 32'h3333_3333, 4'h0);
        read_lit(3'd2, 32'hFFBB_FFDD, "no_change");
        read_lit(3'd6, 32'h0, "unmapped");
        bus_address     = BASE + 32'h28;
        bus_read_enable = 1'b1;
        #1;
        check("outside_rd", {32'b0, bus_read_data}, 64'h0);
        check("outside_sel", {63'b0, selected}, 64'h0);
        bus_address = BASE + 32'h1C;
        #1;
        check("inside_sel", {63'b0, selected}, 64'h1);
        idle(1);

        // Write on the exact increment cycle wins; next increment D+1 later
        wr(3'd0, 32'h0, 4'hF);
        wr(3'd4, 32'h0000_0301, 4'hF);
        idle(3);
        wr(3'd0, 32'h50, 4'hF);
        read_lit(3'd0, 32'h50, "collide");
        idle(2);
        read_lit(3'd0, 32'h50, "collide_hold");
        read_lit(3'd0, 32'h51, "collide_next");

        // Asynchronous reset in the middle of a count
        idle(2);
        #2 reset = 1'b0;
        #1;
        bus_address     = BASE;
        bus_read_enable = 1'b1;
        #1;
        check("midrst_mtime", {32'b0, bus_read_data}, 64'h0);
        check("midrst_irq", {63'b0, timer_interrupt}, 64'h0);
        bus_read_enable = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        wr(3'd4, 32'h0000_0301, 4'hF);
        idle(4);
        read_lit(3'd0, 32'd1, "after_rst_first");

        // Randomized traffic, checked each cycle by the scoreboard
        for (int c = 0; c < 4000; c++) begin
            off = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       d = $urandom;
                default: d = $urandom_range(0, 60);
            endcase
            if (off == 3'd4) d = ($urandom_range(0, 3) == 0) ? $urandom
                                 : ((32'($urandom_range(0, 4)) << 8) | 32'($urandom_range(0, 1)));
            if (off == 3'd1 || off == 3'd3) d = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
            if ($urandom_range(0, 19) == 0)
                bus_address = BASE + 32'($urandom_range(1, 4)) * 32'h20 + {27'b0, off, 2'b00};
            else
                bus_address = BASE | {27'b0, off, 2'($urandom_range(0, 3))};
            bus_write_data   = d;
            bus_byte_enable  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            bus_write_enable = ($urandom_range(0, 9) < 2);
            bus_read_enable  = ($urandom_range(0, 9) < 6);
            @(posedge clock);
            #1;
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
